// File: rtl/axi_read_scheduler.sv
// Shares one AXI read AR/R channel among N_MASTERS requesters, one burst outstanding at a time.
// Define AXI_READ_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi_read_scheduler #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_arvalid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_araddr,
  input  logic [N_MASTERS*LEN_W-1:0]      m_arlen,
  output logic [N_MASTERS-1:0]            m_arready,
  output logic [N_MASTERS-1:0]            m_rvalid,
  output logic [N_MASTERS-1:0]            m_rlast,
  output logic [DATA_W-1:0]               m_rdata,
  input  logic [N_MASTERS-1:0]            m_rready,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  output logic [3:0]                      ARID,
  output logic [LEN_W-1:0]                ARLEN,
  output logic [ADDR_W-1:0]               ARADDR,
  input  logic                            RVALID,
  output logic                            RREADY,
  input  logic                            RLAST,
  input  logic [3:0]                      RID,
  input  logic [DATA_W-1:0]               RDATA,
  output logic                            busy,
  output logic [$clog2(N_MASTERS)-1:0]    grant_idx,
  output logic                            len_err
);

  localparam int unsigned IDX_W  = $clog2(N_MASTERS);
  localparam int unsigned BEAT_W = LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   g_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               len_err_q;
  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic               r_hs;

  // Arbiter: first requester at or after rr_ptr (or lowest index in fixed-priority builds)
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
`ifdef AXI_READ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!arb_hit && m_arvalid[i]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(i);
      end
    end
`else
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!arb_hit && m_arvalid[(int'(rr_ptr) + i) % int'(N_MASTERS)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'((int'(rr_ptr) + i) % int'(N_MASTERS));
      end
    end
`endif
  end

  assign r_hs = (state_q == S_DATA) && RVALID && m_rready[g_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and channel steering; the R path is purely combinational
  always_comb begin
    state_d   = state_q;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    m_rdata   = '0;
    case (state_q)
      S_IDLE: if (arb_hit) state_d = S_ADDR;
      S_ADDR: begin
        ARVALID        = 1'b1;
        m_arready[g_q] = ARREADY;
        if (ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        RREADY        = m_rready[g_q];
        m_rvalid[g_q] = RVALID;
        m_rlast[g_q]  = RLAST;
        m_rdata       = RDATA;
        if (r_hs && RLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latches, beat counter, sticky error and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q       <= '0;
      rr_ptr    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && arb_hit) begin
        g_q    <= arb_idx;
        addr_q <= m_araddr[arb_idx*ADDR_W +: ADDR_W];
        len_q  <= m_arlen[arb_idx*LEN_W +: LEN_W];
      end
      if (state_q == S_ADDR) beat_q <= '0;
      else if (r_hs && beat_q != '1) beat_q <= beat_q + BEAT_W'(1);
      if (state_q == S_DATA) begin
        if (RVALID && RID != 4'(g_q)) len_err_q <= 1'b1;
        if (r_hs && RLAST && beat_q != BEAT_W'(len_q)) len_err_q <= 1'b1;
        if (r_hs && !RLAST && beat_q >= BEAT_W'(len_q)) len_err_q <= 1'b1;
`ifndef AXI_READ_SCHED_FIXED_PRIO_EN
        if (r_hs && RLAST)
          rr_ptr <= (g_q == IDX_W'(N_MASTERS - 1)) ? '0 : g_q + IDX_W'(1);
`endif
      end
    end
  end

  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARID      = 4'(g_q);
  assign busy      = (state_q != S_IDLE);
  assign grant_idx = g_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Table-driven bench for axi_read_scheduler: one row per clock cycle of inputs and expected outputs.
module tb_axi_read_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   m_arvalid = '0;
  logic [77:0]  m_araddr  = {26'h0000300, 26'h0000100, 26'h0000040};
  logic [11:0]  m_arlen   = '0;
  logic [2:0]   m_arready, m_rvalid, m_rlast;
  logic [31:0]  m_rdata;
  logic [2:0]   m_rready = '0;
  logic         ARVALID;
  logic         ARREADY = 1'b0;
  logic [3:0]   ARID;
  logic [3:0]   ARLEN;
  logic [25:0]  ARADDR;
  logic         RVALID = 1'b0;
  logic         RREADY;
  logic         RLAST = 1'b0;
  logic [3:0]   RID = '0;
  logic [31:0]  RDATA = '0;
  logic         busy;
  logic [1:0]   grant_idx;
  logic         len_err;

  int checks = 0;
  int failures = 0;

  axi_read_scheduler dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rready(m_rready),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .busy(busy), .grant_idx(grant_idx), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [2:0]  va;
    logic [11:0] len;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [3:0]  rid;
    logic [2:0]  rready;
    logic [31:0] rdata;
    logic        e_arvalid;
    logic [3:0]  e_arid;
    logic [25:0] e_araddr;
    logic [3:0]  e_arlen;
    logic [2:0]  e_marready;
    logic [2:0]  e_mrvalid;
    logic [2:0]  e_mrlast;
    logic        e_rready;
    logic        e_busy;
    logic [1:0]  e_gidx;
    logic        e_lerr;
  } vec_t;

  vec_t vq[$];

  function automatic logic [25:0] addr_of(input int g);
    return (g == 0) ? 26'h0000040 : (g == 1) ? 26'h0000100 : 26'h0000300;
  endfunction

  function automatic vec_t v_rst();
    vec_t v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_idle(input logic [2:0] va, input logic [11:0] len,
                                  input int g, input logic le);
    vec_t v = '0;
    v.va = va; v.len = len; v.e_gidx = 2'(g); v.e_lerr = le;
    return v;
  endfunction

  function automatic vec_t v_addr(input logic [2:0] va, input logic [11:0] len, input logic ardy,
                                  input int g, input logic [3:0] arlen, input logic le);
    vec_t v = '0;
    v.va = va; v.len = len; v.arready = ardy;
    v.e_arvalid = 1'b1; v.e_arid = 4'(g); v.e_araddr = addr_of(g); v.e_arlen = arlen;
    v.e_marready = ardy ? (3'b001 << g) : 3'b000;
    v.e_busy = 1'b1; v.e_gidx = 2'(g); v.e_lerr = le;
    return v;
  endfunction

  function automatic vec_t v_beat(input logic [2:0] va, input logic [11:0] len, input logic rlast,
                                  input logic [3:0] rid, input logic [2:0] rready,
                                  input int g, input logic le, input logic [31:0] rdata);
    vec_t v = '0;
    v.va = va; v.len = len; v.rvalid = 1'b1; v.rlast = rlast; v.rid = rid;
    v.rready = rready; v.rdata = rdata;
    v.e_mrvalid = 3'b001 << g;
    v.e_mrlast = rlast ? (3'b001 << g) : 3'b000;
    v.e_rready = rready[g];
    v.e_busy = 1'b1; v.e_gidx = 2'(g); v.e_lerr = le;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

`ifdef AXI_READ_SCHED_FIXED_PRIO_EN
  int rr_g[4] = '{0, 0, 0, 0};
`else
  int rr_g[4] = '{0, 1, 2, 0};
`endif

  initial begin
    vec_t r;
    int gprev;

    // Reset values
    vq.push_back(v_rst());

    // Single request: d-cache, addr 0x100, len 3
    vq.push_back(v_idle(3'b010, 12'h030, 0, 1'b0));
    vq.push_back(v_addr(3'b010, 12'h030, 1'b1, 1, 4'd3, 1'b0));
    for (int k = 0; k < 4; k++)
      vq.push_back(v_beat(3'b000, 12'h030, k == 3, 4'd1, 3'b010, 1, 1'b0, 32'hD100_0000 + 32'(k)));
    vq.push_back(v_idle(3'b000, 12'h000, 1, 1'b0));

    // Backpressure: stream buffer, len 7, ARREADY low 5 cycles, m_rready[2] toggling
    vq.push_back(v_idle(3'b100, 12'h700, 1, 1'b0));
    for (int k = 0; k < 5; k++) vq.push_back(v_addr(3'b100, 12'h700, 1'b0, 2, 4'd7, 1'b0));
    vq.push_back(v_addr(3'b100, 12'h700, 1'b1, 2, 4'd7, 1'b0));
    for (int k = 0; k < 15; k++)
      vq.push_back(v_beat(3'b000, 12'h700, k == 14, 4'd2, (k % 2 == 0) ? 3'b100 : 3'b000,
                          2, 1'b0, 32'hB200_0000 + 32'(k)));
    vq.push_back(v_idle(3'b000, 12'h000, 2, 1'b0));

    // Length error: len 3 but RLAST on beat 2; next burst proceeds with len_err still set
    vq.push_back(v_idle(3'b001, 12'h003, 2, 1'b0));
    vq.push_back(v_addr(3'b001, 12'h003, 1'b1, 0, 4'd3, 1'b0));
    vq.push_back(v_beat(3'b000, 12'h003, 1'b0, 4'd0, 3'b001, 0, 1'b0, 32'hE000_0001));
    vq.push_back(v_beat(3'b000, 12'h003, 1'b1, 4'd0, 3'b001, 0, 1'b0, 32'hE000_0002));
    vq.push_back(v_idle(3'b000, 12'h000, 0, 1'b1));
    vq.push_back(v_idle(3'b010, 12'h000, 0, 1'b1));
    vq.push_back(v_addr(3'b010, 12'h000, 1'b1, 1, 4'd0, 1'b1));
    vq.push_back(v_beat(3'b000, 12'h000, 1'b1, 4'd1, 3'b010, 1, 1'b1, 32'hE000_0003));
    vq.push_back(v_idle(3'b000, 12'h000, 1, 1'b1));

    // Reset clears len_err; then ID error: RID=2 while owner is 0
    vq.push_back(v_rst());
    vq.push_back(v_idle(3'b001, 12'h001, 0, 1'b0));
    vq.push_back(v_addr(3'b001, 12'h001, 1'b1, 0, 4'd1, 1'b0));
    vq.push_back(v_beat(3'b000, 12'h001, 1'b0, 4'd2, 3'b001, 0, 1'b0, 32'hAB00_0001));
    vq.push_back(v_beat(3'b000, 12'h001, 1'b1, 4'd0, 3'b001, 0, 1'b1, 32'hAB00_0002));
    vq.push_back(v_idle(3'b000, 12'h000, 0, 1'b1));

    // Reset during beat 2 of 4: outputs drop at once, then a fresh grant starts from index 0
    vq.push_back(v_idle(3'b010, 12'h030, 0, 1'b1));
    vq.push_back(v_addr(3'b010, 12'h030, 1'b1, 1, 4'd3, 1'b1));
    vq.push_back(v_beat(3'b000, 12'h030, 1'b0, 4'd1, 3'b010, 1, 1'b1, 32'h5500_0001));
    r = v_rst();
    r.va = 3'b010; r.len = 12'h030; r.rvalid = 1'b1; r.rid = 4'd1; r.rready = 3'b010;
    r.rdata = 32'h5500_0002;
    vq.push_back(r);
    vq.push_back(v_idle(3'b111, 12'h030, 0, 1'b0));
    vq.push_back(v_addr(3'b111, 12'h030, 1'b1, 0, 4'd0, 1'b0));
    vq.push_back(v_beat(3'b111, 12'h030, 1'b1, 4'd0, 3'b001, 0, 1'b0, 32'h5500_0003));

    // Arbitration with all three requesters held, len 0
    vq.push_back(v_rst());
    gprev = 0;
    for (int n = 0; n < 4; n++) begin
      vq.push_back(v_idle(3'b111, 12'h000, gprev, 1'b0));
      vq.push_back(v_addr(3'b111, 12'h000, 1'b1, rr_g[n], 4'd0, 1'b0));
      vq.push_back(v_beat(3'b111, 12'h000, 1'b1, 4'(rr_g[n]), 3'b111, rr_g[n], 1'b0,
                          32'h7700_0000 + 32'(n)));
      gprev = rr_g[n];
    end
    vq.push_back(v_idle(3'b000, 12'h000, gprev, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; m_arvalid = vq[i].va; m_arlen = vq[i].len; ARREADY = vq[i].arready;
      RVALID = vq[i].rvalid; RLAST = vq[i].rlast; RID = vq[i].rid; m_rready = vq[i].rready;
      RDATA = vq[i].rdata;
      #2;
      chk("arvalid",   i, 32'(ARVALID),   32'(vq[i].e_arvalid));
      chk("m_arready", i, 32'(m_arready), 32'(vq[i].e_marready));
      chk("m_rvalid",  i, 32'(m_rvalid),  32'(vq[i].e_mrvalid));
      chk("m_rlast",   i, 32'(m_rlast),   32'(vq[i].e_mrlast));
      chk("rready",    i, 32'(RREADY),    32'(vq[i].e_rready));
      chk("busy",      i, 32'(busy),      32'(vq[i].e_busy));
      chk("grant_idx", i, 32'(grant_idx), 32'(vq[i].e_gidx));
      chk("len_err",   i, 32'(len_err),   32'(vq[i].e_lerr));
      if (vq[i].e_arvalid) begin
        chk("arid",   i, 32'(ARID),   32'(vq[i].e_arid));
        chk("araddr", i, 32'(ARADDR), 32'(vq[i].e_araddr));
        chk("arlen",  i, 32'(ARLEN),  32'(vq[i].e_arlen));
      end
      if (vq[i].e_mrvalid != 3'b000) chk("m_rdata", i, m_rdata, vq[i].rdata);
      else chk("m_rdata_idle", i, m_rdata, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
